alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle control unit that fetches 16-bit instructions from an external instruction memory and sequences the shared 8-bit ALU (3-bit alu_sel: add, sub, and, or, xor, mul, div, comp).
- Holds a 4x8 register file, program counter and carry flag, and writes ALU results back.
- Sits between instruction memory and the ALU; the ALU itself stays combinational and outside this block.

Parameters:
- PC_W, 8, program counter / instruction address width.
- FETCH_TIMEOUT, 15, maximum cycles FETCH waits for instr_valid before declaring an error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  begin execution at pc 0; sampled only in IDLE, HALTED or ERROR.
- busy  output  1  1 in FETCH/DECODE/EXEC/WB.
- halted  output  1  1 in HALTED.
- error  output  1  1 in ERROR (fetch timeout).
- instr_req  output  1  fetch request, high throughout FETCH.
- instr_addr  output  PC_W  fetch address (= pc).
- instr_data  input  16  instruction word, valid when instr_valid=1.
- instr_valid  input  1  memory response strobe.
- alu_a  output  8  ALU operand A.
- alu_b  output  8  ALU operand B.
- alu_sel  output  3  ALU opcode.
- alu_out  input  8  ALU result (combinational from alu_a/alu_b/alu_sel).
- carry_out  input  1  ALU carry/borrow.
- carry_flag  output  1  carry from the last ALU writeback.
- pc  output  PC_W  current program counter.
- dbg_sel  input  2  register-file read select.
- dbg_data  output  8  reg[dbg_sel], combinational.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; pc=0; ir=0; all registers=0; carry_flag=0.
  - Timeout counter=0; every output 0.
  - Reset asserted mid-instruction aborts it immediately; no partial writeback survives.
- Instruction format, by class [15:14]:
  - 00 ALU: [13:11] alu_sel, [10:9] rd, [8:7] rs1, [6:5] rs2, [4:0] ignored.
  - 01 LDI: [10:9] rd, [7:0] imm; rd <= imm.
  - 10 JMP: pc <= [PC_W-1:0].
  - 11 HALT.
- IDLE: outputs idle. start=1 -> pc<=0, go to FETCH.
- FETCH:
  - instr_req=1, instr_addr=pc.
  - If instr_valid=1: ir<=instr_data, pc<=pc+1 (255 wraps to 0), timeout counter<=0, go to DECODE.
  - Otherwise the counter increments. When counter reaches FETCH_TIMEOUT with no valid, go to ERROR.
  - A response in the same cycle as the request is legal (zero wait).
- DECODE:
  - ALU: go to EXEC.
  - LDI: write rd, go to FETCH.
  - JMP: load pc (overrides the earlier increment), go to FETCH.
  - HALT: go to HALTED.
- EXEC: alu_a=reg[rs1], alu_b=reg[rs2], alu_sel=ir[13:11]. Latch alu_out and carry_out into internal result registers at the clock edge, then go to WB.
- WB: reg[rd]<=result, carry_flag<=latched carry, go to FETCH.
- Operand outputs: alu_a/alu_b/alu_sel are registered and are 0 outside EXEC.
- Results: an 8-bit result is stored exactly as returned (mul truncation and div by zero are the ALU's behaviour, passed through unmodified).
- Register aliasing: rd equal to rs1 or rs2 is legal; sources are read in EXEC, before WB.
- HALTED and ERROR: sticky. pc and registers are held; dbg readable. start=1 restarts at pc 0 with the register file preserved.
- start while busy: ignored.
- instr_valid outside FETCH: ignored.
- Cycle counts at zero wait: ALU=4, LDI/JMP=2, HALT=2 (to halted=1).

Test Plan:
- Program 0x4005 (LDI r0,5), 0x4203 (LDI r1,3), 0x0420 (ADD r2,r0,r1), 0xC000. Bench ALU is the real ALU model, memory is zero wait. Pulse start -> halted=1 exactly 10 cycles later; dbg_sel=2 gives dbg_data=8; carry_flag=0; pc=4.
- Same program with ALU class op sweep: alu_sel 001..111 replacing ADD -> r2 = 2 (sub), 1 (and), 7 (or), 6 (xor), 15 (mul), 1 (div), ALU comp value. alu_a=5 and alu_b=3 visible during EXEC only.
- Memory with 3-cycle response latency -> instr_req held high, state held in FETCH until valid. Total for the four-instruction program is 10+12=22 cycles.
- instr_valid never asserted -> error=1 after FETCH_TIMEOUT+1 cycles in FETCH, busy=0. A subsequent start with a working memory completes normally.
- 0x8000 at pc 0 (JMP 0) with instr_valid tied high -> pc alternates 0/1 and never increments past 1. Asynchronous reset=0 mid-DECODE -> all outputs 0 in the same cycle, registers cleared.
- Wrap-around: JMP to 255 (0x80FF) with LDI at 255 -> pc wraps to 0 after that fetch. Register aliasing check: ADD r0,r0,r0 with r0=0x90 -> r0=0x20, carry_flag=1.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving an external combinational ALU.
// Holds a 4x8 register file, the program counter and the carry flag.
module alu_sequencer #(
   parameter int PC_W          = 8,
   parameter int FETCH_TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            busy,
   output logic            halted,
   output logic            error,
   output logic            instr_req,
   output logic [PC_W-1:0] instr_addr,
   input  logic [15:0]     instr_data,
   input  logic            instr_valid,
   output logic [7:0]      alu_a,
   output logic [7:0]      alu_b,
   output logic [2:0]      alu_sel,
   input  logic [7:0]      alu_out,
   input  logic            carry_out,
   output logic            carry_flag,
   output logic [PC_W-1:0] pc,
   input  logic [1:0]      dbg_sel,
   output logic [7:0]      dbg_data
);

   localparam int TO_W = $clog2(FETCH_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(FETCH_TIMEOUT);

   localparam logic [1:0] C_ALU  = 2'b00;
   localparam logic [1:0] C_LDI  = 2'b01;
   localparam logic [1:0] C_JMP  = 2'b10;
   localparam logic [1:0] C_HALT = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_HALTED,
      S_ERROR
   } state_t;

   state_t           state, state_nxt;
   logic [15:0]      ir;
   logic [3:0][7:0]  rf;
   logic [7:0]       res;
   logic             res_c;
   logic [TO_W-1:0]  to_cnt;

   logic [1:0] op_class;
   logic [1:0] rd, rs1, rs2;

   assign op_class = ir[15:14];
   assign rd       = ir[10:9];
   assign rs1      = ir[8:7];
   assign rs2      = ir[6:5];

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_HALTED, S_ERROR:
            if (start) state_nxt = S_FETCH;
         S_FETCH:
            if (instr_valid)           state_nxt = S_DECODE;
            else if (to_cnt == TO_MAX) state_nxt = S_ERROR;
         S_DECODE:
            case (op_class)
               C_ALU:   state_nxt = S_EXEC;
               C_HALT:  state_nxt = S_HALTED;
               default: state_nxt = S_FETCH;
            endcase
         S_EXEC:  state_nxt = S_WB;
         S_WB:    state_nxt = S_FETCH;
         default: state_nxt = S_IDLE;
      endcase
   end

   // status outputs decoded from state
   always_comb begin
      busy      = 1'b0;
      halted    = 1'b0;
      error     = 1'b0;
      instr_req = 1'b0;
      case (state)
         S_FETCH: begin
            busy      = 1'b1;
            instr_req = 1'b1;
         end
         S_DECODE, S_EXEC, S_WB: busy = 1'b1;
         S_HALTED: halted = 1'b1;
         S_ERROR:  error  = 1'b1;
         default: ;
      endcase
   end

   assign instr_addr = pc;
   assign dbg_data   = rf[dbg_sel];

   // fetch wait counter; any non-FETCH cycle rearms it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                              to_cnt <= '0;
      else if (state == S_FETCH && !instr_valid) to_cnt <= to_cnt + 1'b1;
      else                                     to_cnt <= '0;
   end

   // datapath: operands are driven only while in EXEC, so they default to 0 each cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc         <= '0;
         ir         <= '0;
         rf         <= '0;
         res        <= '0;
         res_c      <= 1'b0;
         carry_flag <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_sel    <= '0;
      end else begin
         alu_a   <= '0;
         alu_b   <= '0;
         alu_sel <= '0;
         case (state)
            S_IDLE, S_HALTED, S_ERROR:
               if (start) pc <= '0;
            S_FETCH:
               if (instr_valid) begin
                  ir <= instr_data;
                  pc <= pc + 1'b1;
               end
            S_DECODE:
               case (op_class)
                  C_ALU: begin
                     alu_a   <= rf[rs1];
                     alu_b   <= rf[rs2];
                     alu_sel <= ir[13:11];
                  end
                  C_LDI:   rf[rd] <= ir[7:0];
                  C_JMP:   pc     <= ir[PC_W-1:0];
                  default: ;
               endcase
            S_EXEC: begin
               res   <= alu_out;
               res_c <= carry_out;
            end
            S_WB: begin
               rf[rd]     <= res;
               carry_flag <= res_c;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus queues expectations, a monitor checks them
// on halted/error rising edges or on explicit snapshot requests.
module tb_alu_sequencer;

   localparam int PC_W = 8;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            start = 1'b0;
   logic            busy, halted, error, instr_req;
   logic [PC_W-1:0] instr_addr, pc;
   logic [15:0]     instr_data;
   logic            instr_valid;
   logic [7:0]      alu_a, alu_b, alu_out;
   logic [2:0]      alu_sel;
   logic            carry_out, carry_flag;
   logic [1:0]      dbg_sel = 2'd0;
   logic [7:0]      dbg_data;

   alu_sequencer #(.PC_W(PC_W), .FETCH_TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .start(start),
      .busy(busy), .halted(halted), .error(error),
      .instr_req(instr_req), .instr_addr(instr_addr),
      .instr_data(instr_data), .instr_valid(instr_valid),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .carry_out(carry_out),
      .carry_flag(carry_flag), .pc(pc),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   // reference ALU
   logic [8:0]  alu_t;
   logic [15:0] mul16;
   always_comb begin
      mul16 = 16'(alu_a) * 16'(alu_b);
      alu_t = 9'd0;
      case (alu_sel)
         3'd0: alu_t = {1'b0, alu_a} + {1'b0, alu_b};
         3'd1: alu_t = {1'b0, alu_a} - {1'b0, alu_b};
         3'd2: alu_t = {1'b0, alu_a & alu_b};
         3'd3: alu_t = {1'b0, alu_a | alu_b};
         3'd4: alu_t = {1'b0, alu_a ^ alu_b};
         3'd5: alu_t = {1'b0, mul16[7:0]};
         3'd6: alu_t = (alu_b == 8'd0) ? 9'h0FF : {1'b0, alu_a / alu_b};
         default: alu_t = {8'd0, alu_a > alu_b};
      endcase
   end
   assign alu_out   = alu_t[7:0];
   assign carry_out = alu_t[8];

   // instruction memory with programmable latency
   logic [15:0] mem [0:255];
   bit mem_en = 1'b1, tie_high = 1'b0;
   int lat = 0, wcnt = 0, cyc = 0;
   assign instr_data = mem[instr_addr];
   always_comb instr_valid = mem_en && (tie_high || (instr_req && wcnt == lat));
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!instr_req || instr_valid) wcnt <= 0;
      else                           wcnt <= wcnt + 1;
   end

   typedef struct {
      bit snap;
      int cycles, busy, halted, error, req, pc, carry;
      int ecnt, ea, eb;
      int aa, ab, asel;
      logic [3:0]      rmask;
      logic [3:0][7:0] regs;
   } exp_t;

   exp_t  q[$];
   string qn[$];
   int    n_total = 0, n_pass = 0;
   int    t0 = 0, snap_cnt = 0;
   int    sweep_exp [7] = '{2, 1, 7, 6, 15, 1, 1};

   task automatic chk(string nm, int act, int expv);
      n_total++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
   endtask

   // monitor
   initial begin : monitor
      bit ph, pe, fire;
      int ecnt, la, lb, snap_seen;
      exp_t e;
      string nm;
      ph = 0; pe = 0; ecnt = 0; la = 0; lb = 0; snap_seen = 0;
      forever begin
         @(negedge clk);
         if (alu_a != 0 || alu_b != 0 || alu_sel != 0) begin
            ecnt++; la = alu_a; lb = alu_b;
         end
         if (q.size() > 0) begin
            e = q[0];
            fire = e.snap ? (snap_cnt != snap_seen) : ((halted && !ph) || (error && !pe));
            if (fire) begin
               nm = qn[0];
               if (e.cycles >= 0) chk({nm, ".cycles"}, cyc - t0, e.cycles);
               if (e.busy   >= 0) chk({nm, ".busy"},   int'(busy),   e.busy);
               if (e.halted >= 0) chk({nm, ".halted"}, int'(halted), e.halted);
               if (e.error  >= 0) chk({nm, ".error"},  int'(error),  e.error);
               if (e.req    >= 0) chk({nm, ".req"},    int'(instr_req), e.req);
               if (e.pc >= 0) begin
                  chk({nm, ".pc"},   int'(pc),         e.pc);
                  chk({nm, ".addr"}, int'(instr_addr), e.pc);
               end
               if (e.carry >= 0) chk({nm, ".carry"}, int'(carry_flag), e.carry);
               if (e.ecnt >= 0) begin
                  chk({nm, ".exec_cycles"}, ecnt, e.ecnt);
                  if (e.ecnt > 0) begin
                     chk({nm, ".exec_a"}, la, e.ea);
                     chk({nm, ".exec_b"}, lb, e.eb);
                  end
               end
               if (e.aa >= 0) begin
                  chk({nm, ".alu_a"},   int'(alu_a),   e.aa);
                  chk({nm, ".alu_b"},   int'(alu_b),   e.ab);
                  chk({nm, ".alu_sel"}, int'(alu_sel), e.asel);
               end
               for (int i = 0; i < 4; i++) begin
                  if (e.rmask[i]) begin
                     dbg_sel = 2'(i);
                     #1;
                     chk($sformatf("%s.r%0d", nm, i), int'(dbg_data), int'(e.regs[i]));
                  end
               end
               if (e.snap) snap_seen++;
               void'(q.pop_front());
               void'(qn.pop_front());
               ecnt = 0;
            end
         end
         ph = halted; pe = error;
      end
   end

   function automatic exp_t blank();
      exp_t e;
      e.snap = 0; e.cycles = -1; e.busy = -1; e.halted = -1; e.error = -1; e.req = -1;
      e.pc = -1; e.carry = -1; e.ecnt = -1; e.ea = 0; e.eb = 0;
      e.aa = -1; e.ab = -1; e.asel = -1; e.rmask = 4'b0; e.regs = '0;
      return e;
   endfunction

   function automatic exp_t zero_exp();
      exp_t e = blank();
      e.snap = 1; e.busy = 0; e.halted = 0; e.error = 0; e.req = 0; e.pc = 0; e.carry = 0;
      e.aa = 0; e.ab = 0; e.asel = 0; e.rmask = 4'hF;
      return e;
   endfunction

   function automatic exp_t done_exp(int cycles, int pcv, logic [7:0] r0, logic [7:0] r1,
                                     logic [7:0] r2, int carry, int a, int b);
      exp_t e = blank();
      e.cycles = cycles; e.busy = 0; e.halted = 1; e.error = 0; e.req = 0;
      e.pc = pcv; e.carry = carry; e.ecnt = 1; e.ea = a; e.eb = b;
      e.aa = 0; e.ab = 0; e.asel = 0; e.rmask = 4'b0111;
      e.regs[0] = r0; e.regs[1] = r1; e.regs[2] = r2;
      return e;
   endfunction

   function automatic exp_t pc_snap(int pcv, int req);
      exp_t e = blank();
      e.snap = 1; e.busy = 1; e.halted = 0; e.error = 0; e.req = req; e.pc = pcv;
      return e;
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'hC000;
   endtask

   task automatic load_basic(logic [15:0] op);
      clear_mem();
      mem[0] = 16'h4005; mem[1] = 16'h4203; mem[2] = op; mem[3] = 16'hC000;
   endtask

   task automatic wait_empty(string nm, int budget);
      for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         n_total++;
         $display("FAIL %s: timeout with %0d expectations pending, required 0", nm, q.size());
         q.delete(); qn.delete();
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      t0 = cyc;
   endtask

   task automatic run_prog(string nm, exp_t e);
      q.push_back(e); qn.push_back(nm);
      pulse_start();
      wait_empty(nm, 200);
   endtask

   task automatic do_snap(string nm, exp_t e);
      q.push_back(e); qn.push_back(nm);
      snap_cnt++;
   endtask

   task automatic pulse_reset();
      @(negedge clk) reset = 1'b0;
      @(negedge clk) reset = 1'b1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      exp_t e;
      clear_mem();
      #1;
      do_snap("reset", zero_exp());
      wait_empty("reset", 10);
      @(negedge clk) reset = 1'b1;

      load_basic(16'h0420);
      run_prog("add", done_exp(10, 4, 8'd5, 8'd3, 8'd8, 0, 5, 3));

      for (int i = 0; i < 7; i++) begin
         load_basic(16'((i + 1) << 11) | 16'h0420);
         run_prog($sformatf("sel%0d", i + 1),
                  done_exp(10, 4, 8'd5, 8'd3, 8'(sweep_exp[i]), 0, 5, 3));
      end

      lat = 3;
      load_basic(16'h0420);
      run_prog("latency3", done_exp(22, 4, 8'd5, 8'd3, 8'd8, 0, 5, 3));
      lat = 0;

      mem_en = 1'b0;
      e = done_exp(16, 0, 8'd5, 8'd3, 8'd8, 0, 0, 0);
      e.halted = 0; e.error = 1; e.ecnt = 0;
      run_prog("timeout", e);
      mem_en = 1'b1;
      run_prog("restart", done_exp(10, 4, 8'd5, 8'd3, 8'd8, 0, 5, 3));

      clear_mem();
      mem[0] = 16'h4090; mem[1] = 16'h0000; mem[2] = 16'hC000;
      run_prog("alias", done_exp(8, 3, 8'h20, 8'd3, 8'd8, 1, 8'h90, 8'h90));

      // JMP 0 with a permanently valid memory
      clear_mem();
      mem[0] = 16'h8000;
      tie_high = 1'b1;
      pulse_start();
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         do_snap($sformatf("jmp0_c%0d", k), pc_snap(k % 2, (k % 2 == 0) ? 1 : 0));
      end
      wait_empty("jmp0", 10);
      pulse_reset();
      tie_high = 1'b0;

      // JMP 255 then an LDI at 255: pc wraps to 0
      clear_mem();
      mem[0] = 16'h80FF; mem[255] = 16'h4677;
      pulse_start();
      @(posedge clk);
      @(posedge clk); #1;
      do_snap("wrap_fetch255", pc_snap(255, 1));
      @(posedge clk); #1;
      do_snap("wrap_decode", pc_snap(0, 0));
      @(posedge clk); #1;
      e = pc_snap(0, 1);
      e.rmask = 4'b1001; e.regs[3] = 8'h77; e.regs[0] = 8'h00;
      do_snap("wrap_ldi", e);
      wait_empty("wrap", 10);
      pulse_reset();

      // asynchronous reset while decoding the second LDI
      load_basic(16'h0420);
      pulse_start();
      @(posedge clk);
      @(posedge clk); #1;
      e = pc_snap(1, 1);
      e.rmask = 4'b0001; e.regs[0] = 8'd5;
      do_snap("pre_reset", e);
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      do_snap("mid_decode_reset", zero_exp());
      wait_empty("mid_decode_reset", 10);
      @(negedge clk) reset = 1'b1;

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
